// File: rtl/mem_access_stage_if.sv
// Data-memory bridge bus between the ME stage and the memory.
// The stage is the master: it raises req and holds the address and lane fields until ack.
// rdata is valid in the same cycle as ack for reads.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the RISC-V pipeline.
// Takes the EX/ME address, store data and memory controls and runs one req/ack
// transaction on the data-memory bus. The pipeline is stalled until the access completes.
// Store data is replicated onto byte lanes, and load data is extracted and extended.
// Optional feature macro: MEM_MISALIGN_CHECK_EN. When it is defined, misaligned half/word
// accesses are rejected with a one-cycle misalign_out pulse. When it is not defined, the
// low address bits are ignored for half and word accesses.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read_in,
    input  logic                mem_write_en_in,
    input  logic                mem_sign_in,
    input  logic [1:0]          mem_length_in,
    input  logic [31:0]         alu_result_in,
    input  logic [31:0]         write_data_in,
    mem_access_stage_if.master  bus,
    output logic [31:0]         load_data_out,
    output logic                stall_out,
    output logic                misalign_out
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state;
    logic        access_req;
    logic        misaligned;
    logic [3:0]  next_be;
    logic [31:0] next_wdata;
    logic [1:0]  acc_offset;
    logic [1:0]  acc_length;
    logic        acc_sign;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    assign access_req = mem_read_in | mem_write_en_in;

    // Byte-lane placement of store data; reads leave every lane disabled
    always_comb begin
        next_be    = 4'b0000;
        next_wdata = 32'h0;
        if (mem_write_en_in) begin
            case (mem_length_in)
                2'b00: begin
                    next_be    = 4'b0001 << alu_result_in[1:0];
                    next_wdata = {4{write_data_in[7:0]}};
                end
                2'b01: begin
                    next_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                    next_wdata = {2{write_data_in[15:0]}};
                end
                default: begin
                    next_be    = 4'b1111;
                    next_wdata = write_data_in;
                end
            endcase
        end
    end

    // Alignment check of the incoming access; it is always aligned when the check is disabled
    always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
        misaligned = access_req &&
                     (((mem_length_in == 2'b01) && alu_result_in[0]) ||
                      (mem_length_in[1] && (alu_result_in[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif
    end

    // Load extraction from the read word, using the offset/size/sign captured at request time
    always_comb begin
        case (acc_offset)
            2'd0:    load_byte = bus.rdata[7:0];
            2'd1:    load_byte = bus.rdata[15:8];
            2'd2:    load_byte = bus.rdata[23:16];
            default: load_byte = bus.rdata[31:24];
        endcase
        load_half = acc_offset[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (acc_length)
            2'b00:   load_ext = {{24{acc_sign & load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{16{acc_sign & load_half[15]}}, load_half};
            default: load_ext = bus.rdata;
        endcase
    end

    // Stall is combinational so the detect cycle already holds the upstream stages
    always_comb begin
        stall_out = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall_out = access_req && !misaligned;
                REQ:     stall_out = 1'b1;
                default: stall_out = 1'b0;
            endcase
        end
    end

    // Access sequencing: capture the request in IDLE, hold it until ack in REQ, release in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.req       <= 1'b0;
            bus.we        <= 1'b0;
            bus.addr      <= '0;
            bus.be        <= 4'b0000;
            bus.wdata     <= 32'h0;
            load_data_out <= 32'h0;
            misalign_out  <= 1'b0;
            acc_offset    <= 2'b00;
            acc_length    <= 2'b00;
            acc_sign      <= 1'b0;
        end else begin
            misalign_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_req) begin
                        if (misaligned) begin
                            misalign_out <= 1'b1;
                        end else begin
                            bus.req    <= 1'b1;
                            bus.we     <= mem_write_en_in;
                            bus.addr   <= {alu_result_in[ADDR_W-1:2], 2'b00};
                            bus.be     <= next_be;
                            bus.wdata  <= next_wdata;
                            acc_offset <= alu_result_in[1:0];
                            acc_length <= mem_length_in;
                            acc_sign   <= mem_sign_in;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        if (!bus.we) begin
                            load_data_out <= load_ext;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// The driver pushes expected bus transactions into a queue and pushes memory responses to a
// responder process. A monitor pops and compares the queue at each bus handshake and at the
// DONE cycle that follows it.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in;
    logic        mem_write_en_in;
    logic        mem_sign_in;
    logic [1:0]  mem_length_in;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic [31:0] load_data_out;
    logic        stall_out;
    logic        misalign_out;

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read_in     (mem_read_in),
        .mem_write_en_in (mem_write_en_in),
        .mem_sign_in     (mem_sign_in),
        .mem_length_in   (mem_length_in),
        .alu_result_in   (alu_result_in),
        .write_data_in   (write_data_in),
        .bus             (bus),
        .load_data_out   (load_data_out),
        .stall_out       (stall_out),
        .misalign_out    (misalign_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        sign;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          waits;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
        int          stalls;
        int          reqs;
    } exp_t;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
    } resp_t;

    exp_t        sb_q[$];
    resp_t       resp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_load = 32'h0;
    bit          manual = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic rd, input logic wr, input logic sign,
                                  input logic [1:0] len, input logic [31:0] addr,
                                  input logic [31:0] data, input int waits,
                                  input logic [31:0] rdata);
        op_t o;
        o.rd = rd; o.wr = wr; o.sign = sign; o.len = len; o.addr = addr;
        o.data = data; o.waits = waits; o.rdata = rdata;
        return o;
    endfunction

    function automatic bit model_misaligned(input op_t op);
`ifdef MEM_MISALIGN_CHECK_EN
        return (op.rd || op.wr) &&
               ((op.len == 2'd1 && op.addr[0]) || (op.len >= 2'd2 && op.addr[1:0] != 2'd0));
`else
        return 1'b0;
`endif
    endfunction

    // Reference rules written arithmetically: lane masks, replication by multiplication, extension by subtraction
    function automatic logic [3:0] model_be(input op_t op);
        int off = int'(op.addr[1:0]);
        if (!op.wr) return 4'd0;
        if (op.len == 2'd0) return 4'((1 << off) & 15);
        if (op.len == 2'd1) return 4'((3 << (2 * int'(op.addr[1]))) & 15);
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input op_t op);
        if (op.len == 2'd0) return (op.data & 32'hFF) * 32'h01010101;
        if (op.len == 2'd1) return (op.data & 32'hFFFF) * 32'h00010001;
        return op.data;
    endfunction

    function automatic logic [31:0] model_extract(input op_t op);
        logic [31:0] v;
        int off = int'(op.addr[1:0]);
        if (op.len == 2'd0) begin
            v = (op.rdata >> (8 * off)) & 32'hFF;
            if (op.sign && v >= 32'd128) v = v - 32'd256;
        end else if (op.len == 2'd1) begin
            v = (op.rdata >> (16 * int'(op.addr[1]))) & 32'hFFFF;
            if (op.sign && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = op.rdata;
        end
        return v;
    endfunction

    task automatic driveIdle();
        mem_read_in     = 1'b0;
        mem_write_en_in = 1'b0;
        mem_sign_in     = 1'b0;
        mem_length_in   = 2'd0;
        alu_result_in   = 32'h0;
        write_data_in   = 32'h0;
    endtask

    task automatic driveOp(input op_t op);
        mem_read_in     = op.rd;
        mem_write_en_in = op.wr;
        mem_sign_in     = op.sign;
        mem_length_in   = op.len;
        alu_result_in   = op.addr;
        write_data_in   = op.data;
    endtask

    // Called just after a rising edge; returns just after a rising edge
    task automatic applyStimulus(input op_t op, input int gap);
        exp_t  e;
        resp_t r;
        int    n;
        if (model_misaligned(op)) begin
            driveOp(op);
            @(negedge clk);
            checkOutput("misalign_no_stall", 32'(stall_out), 32'd0);
            @(posedge clk); #2;
            driveIdle();
            @(negedge clk);
            checkOutput("misalign_pulse", 32'(misalign_out), 32'd1);
            checkOutput("misalign_no_req", 32'(bus.req), 32'd0);
            @(posedge clk); #2;
            @(negedge clk);
            checkOutput("misalign_pulse_end", 32'(misalign_out), 32'd0);
            checkOutput("misalign_load_kept", load_data_out, model_load);
            @(posedge clk); #2;
            return;
        end
        if (!op.wr && op.rd) model_load = model_extract(op);
        e.addr   = op.addr & 32'hFFFF_FFFC;
        e.we     = op.wr;
        e.be     = model_be(op);
        e.wdata  = model_wdata(op);
        e.load   = model_load;
        e.stalls = 2 + op.waits;
        e.reqs   = 1 + op.waits;
        r.waits  = op.waits;
        r.rdata  = op.rdata;
        resp_q.push_back(r);
        sb_q.push_back(e);
        driveOp(op);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_out === 1'b1 && n < 64);
        if (n >= 64) checkOutput("stall_timeout", 32'd1, 32'd0);
        @(posedge clk); #2;
        driveIdle();
        repeat (gap) begin
            @(posedge clk); #2;
        end
    endtask

    // Memory responder: acknowledges after the queued wait count, and acks randomly while no request is pending
    initial begin : responder
        resp_t cur;
        bit    active = 1'b0;
        int    cnt = 0;
        cur.waits = 0;
        cur.rdata = 32'h0;
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (manual) begin
                active = 1'b0;
            end else if (rst) begin
                bus.ack = 1'b0;
                active  = 1'b0;
            end else if (bus.req) begin
                if (!active) begin
                    if (resp_q.size() == 0) begin
                        checkOutput("resp_underflow", 32'd1, 32'd0);
                        cur.waits = 0;
                        cur.rdata = 32'h0;
                    end else begin
                        cur = resp_q.pop_front();
                    end
                    active = 1'b1;
                    cnt    = 0;
                end
                if (cnt == cur.waits) begin
                    bus.ack   = 1'b1;
                    bus.rdata = cur.rdata;
                    active    = 1'b0;
                end else begin
                    bus.ack   = 1'b0;
                    bus.rdata = $urandom;
                    cnt++;
                end
            end else begin
                bus.ack   = ($urandom_range(0, 3) == 0);
                bus.rdata = $urandom;
            end
        end
    end

    // Monitor: compares bus fields at each handshake, then the release cycle and load result one cycle later
    initial begin : monitor
        exp_t cur;
        bit   pending = 1'b0;
        int   stall_cnt = 0;
        int   req_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
                req_cnt   = 0;
                pending   = 1'b0;
            end else begin
                if (pending) begin
                    checkOutput("done_stall_low", 32'(stall_out), 32'd0);
                    checkOutput("done_req_low", 32'(bus.req), 32'd0);
                    checkOutput("load_data", load_data_out, cur.load);
                    checkOutput("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
                    checkOutput("req_cycles", 32'(req_cnt), 32'(cur.reqs));
                    stall_cnt = 0;
                    req_cnt   = 0;
                    pending   = 1'b0;
                end
                if (stall_out) stall_cnt++;
                if (bus.req) req_cnt++;
                if (bus.req && bus.ack) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        checkOutput("bus_addr", bus.addr, cur.addr);
                        checkOutput("bus_we", 32'(bus.we), 32'(cur.we));
                        checkOutput("bus_be", 32'(bus.be), 32'(cur.be));
                        if (cur.we) checkOutput("bus_wdata", bus.wdata, cur.wdata);
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        op_t op;
        rst = 1'b1;
        driveIdle();
        mem_read_in = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        checkOutput("reset_stall_forced_low", 32'(stall_out), 32'd0);
        checkOutput("reset_req", 32'(bus.req), 32'd0);
        checkOutput("reset_load", load_data_out, 32'd0);
        checkOutput("reset_be", 32'(bus.be), 32'd0);
        checkOutput("reset_addr", bus.addr, 32'd0);
        checkOutput("reset_misalign", 32'(misalign_out), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        driveIdle();
        @(posedge clk); #2;

        applyStimulus(mk_op(1'b0, 1'b1, 1'b0, 2'd2, 32'h104, 32'hDEADBEEF, 2, 32'h0), 1);
        applyStimulus(mk_op(1'b1, 1'b0, 1'b1, 2'd0, 32'h203, 32'h0, 0, 32'h80112233), 0);
        applyStimulus(mk_op(1'b1, 1'b0, 1'b0, 2'd1, 32'h202, 32'h0, 1, 32'h9ABC1234), 2);
        applyStimulus(mk_op(1'b0, 1'b1, 1'b0, 2'd1, 32'h202, 32'h5566, 0, 32'h0), 1);
        applyStimulus(mk_op(1'b1, 1'b1, 1'b1, 2'd0, 32'h301, 32'h000000A5, 1, 32'hFFFFFFFF), 3);
        applyStimulus(mk_op(1'b0, 1'b1, 1'b0, 2'd2, 32'h102, 32'h11223344, 0, 32'h0), 1);
        applyStimulus(mk_op(1'b1, 1'b0, 1'b0, 2'd2, 32'h102, 32'h0, 0, 32'hCAFEF00D), 1);
        applyStimulus(mk_op(1'b1, 1'b0, 1'b1, 2'd1, 32'h206, 32'h0, 0, 32'h8001FFFF), 0);

        // Reset during REQ with an ack in the same cycle: the ack must be discarded
        manual  = 1'b1;
        bus.ack = 1'b0;
        driveOp(mk_op(1'b1, 1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 0, 32'h0));
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (bus.req !== 1'b1 && n < 20);
        if (n >= 20) checkOutput("rst_test_req_timeout", 32'd1, 32'd0);
        rst       = 1'b1;
        bus.ack   = 1'b1;
        bus.rdata = 32'h12345678;
        @(posedge clk); #2;
        bus.ack = 1'b0;
        driveIdle();
        @(negedge clk);
        checkOutput("rst_in_req_bus_req", 32'(bus.req), 32'd0);
        checkOutput("rst_in_req_load", load_data_out, 32'd0);
        checkOutput("rst_in_req_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #2;
        rst        = 1'b0;
        manual     = 1'b0;
        model_load = 32'h0;
        @(posedge clk); #2;

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind    = $urandom_range(0, 2);
            op.rd   = (kind != 1);
            op.wr   = (kind != 0);
            op.sign = 1'($urandom_range(0, 1));
            op.len  = 2'($urandom_range(0, 3));
            op.addr = $urandom & 32'h0000FFFF;
            op.data = $urandom;
            op.rdata = $urandom;
            op.waits = $urandom_range(0, 3);
            applyStimulus(op, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        checkOutput("responses_drained", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
